trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter VECTORED_EN, default 1, enables mtvec vectored mode for interrupts.
REQ-002 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 exc_valid_i  in  1  synchronous exception request, held until accepted.
REQ-005 exc_cause_i  in  4  exception code.
REQ-006 exc_pc_i  in  32  PC of the faulting instruction.
REQ-007 exc_tval_i  in  32  trap value.
REQ-008 mret_i  in  1  MRET request, held until accepted.
REQ-009 irq_i  in  3  pending lines {MEI, MTI, MSI}, level.
REQ-010 next_pc_i  in  32  PC of the next unretired instruction, saved on interrupt.
REQ-011 mstatus_i, mie_i, mtvec_i, mepc_i  in  32 each  current CSR values.
REQ-012 redirect_ready_i  in  1  fetch accepts the redirect.
REQ-013 busy_o  out  1  trap sequence in progress; pipeline stalls.
REQ-014 flush_o  out  1  one-cycle pipeline flush.
REQ-015 we_exc_o  out  1  one-cycle CSR update strobe.
REQ-016 is_int_o  out  1  qualifies we_exc_o as an interrupt entry.
REQ-017 mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o, mip_d_o  out  32 each  CSR write data.
REQ-018 redirect_valid_o  out  1, redirect_pc_o  out  32  new fetch PC.

Function
REQ-019 The FSM SHALL have states IDLE, CAPTURE, WRITE, RET, REDIRECT.
REQ-020 Requests SHALL be sampled only in IDLE, with priority exception > MRET > interrupt.
REQ-021 An interrupt SHALL be taken only if mstatus_i[3]=1 and (irq_i masked by mie_i bits 11/7/3) is nonzero; priority MEI > MSI > MTI.
REQ-022 IDLE->CAPTURE on an accepted exception or interrupt; IDLE->RET on an accepted MRET; otherwise stay in IDLE.
REQ-023 In CAPTURE, flush_o=1 for exactly one cycle; cause, PC, tval and type SHALL be latched on entry, then go to WRITE.
REQ-024 In WRITE, we_exc_o=1 for one cycle with the outputs below, then go to REDIRECT:
- mepc_d_o = latched PC with bits [1:0] cleared.
- mcause_d_o = {int,27'b0,cause}, where interrupt causes are 11, 3 or 7.
- mtval_d_o = tval for an exception, 0 for an interrupt.
- mstatus_d_o: MPIE=MIE, MIE=0, MPP=2'b11, other bits unchanged.
- is_int_o = 1 for an interrupt; mip_d_o = irq_i mapped to bits 11/7/3.
REQ-025 In RET, flush_o=1 and we_exc_o=1 for one cycle with is_int_o=0, mstatus_d_o MIE=MPIE and MPIE=1; mcause, mepc and mtval SHALL keep their current values; then go to REDIRECT.
REQ-026 Redirect PC rules:
- Exception: mtvec_i & ~3.
- Interrupt with VECTORED_EN=1 and mtvec_i[1:0]=01: (mtvec_i & ~3) + 4*cause, 32-bit wrap.
- MRET: mepc_i & ~3.
REQ-027 In REDIRECT, redirect_valid_o=1 and redirect_pc_o SHALL stay stable until redirect_ready_i=1, then go to IDLE; 0 wait cycles is legal.
REQ-028 busy_o=1 in every state except IDLE.
REQ-029 Minimum latency from an accepted request to redirect_valid_o SHALL be 3 cycles for a trap and 2 cycles for MRET.
REQ-030 Requests arriving while busy_o=1 SHALL be ignored; requesters hold them.
REQ-031 An interrupt line deasserting after acceptance SHALL NOT abort the sequence.
REQ-032 Simultaneous exception and interrupt: the exception SHALL be taken; the interrupt is re-evaluated in IDLE.

Reset
REQ-033 Asserting rst_ni low SHALL force IDLE immediately, including mid-sequence.
REQ-034 In reset, every output and latched register SHALL be 0.
REQ-035 After rst_ni rises, the first request SHALL be accepted no earlier than the next rising edge.

Structure
REQ-036 CSR addresses, mcause codes, mstatus bit positions (MIE=3, MPIE=7, MPP=12:11) and the FSM state enum SHALL live in shared package rv_csr_pkg.
REQ-037 One sub-module, irq_prio, SHALL hold the combinational interrupt masking and priority encoding; everything else stays in trap_ctrl.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
- Illegal instruction: exc_valid_i, cause=2, pc=0x100, tval=0xDEAD, mtvec=0x200, mstatus.MIE=1 -> flush, then we_exc_o with mepc=0x100, mcause=2, mtval=0xDEAD, MIE=0, MPIE=1; redirect 0x200.
- Vectored timer interrupt: mtvec=0x401, irq MTI, mie[7]=1, mstatus.MIE=1, next_pc=0x80 -> mcause=0x80000007, mepc=0x80, mtval=0; redirect 0x41C.
- MRET: mepc=0x84, mstatus MPIE=1, MIE=0 -> we_exc_o with is_int_o=0, MIE=1; redirect 0x84 after 2 cycles.
- Exception and MEI in the same cycle -> exception cause taken; MEI taken after return to IDLE only if MIE is re-enabled.
- redirect_ready_i held low 5 cycles -> redirect_valid_o and redirect_pc_o stable for 5 cycles; IDLE one cycle after ready.
- rst_ni asserted low during WRITE -> all outputs 0 immediately; a new exception after release completes normally.

Source files
------------

// File: rtl/rv_csr_pkg.sv
// Shared machine-mode CSR definitions: addresses, cause codes, mstatus
// field positions, trap FSM state encoding and mstatus update helpers.
package rv_csr_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // Interrupt cause codes (also the mie/mip bit positions)
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    // mstatus field positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // mie / mip enable and pending bit positions
    localparam int MIX_MSI = 3;
    localparam int MIX_MTI = 7;
    localparam int MIX_MEI = 11;

    // mtvec mode value selecting vectored interrupts
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CAPTURE  = 3'd1,
        ST_WRITE    = 3'd2,
        ST_RET      = 3'd3,
        ST_REDIRECT = 3'd4
    } trap_state_e;

    // Place the {MEI, MTI, MSI} request lines on their mip bit positions.
    function automatic logic [31:0] mip_map(input logic [2:0] irq);
        logic [31:0] r;
        r          = 32'd0;
        r[MIX_MEI] = irq[2];
        r[MIX_MTI] = irq[1];
        r[MIX_MSI] = irq[0];
        return r;
    endfunction

    // mstatus on trap entry: stash MIE in MPIE, disable, return to M-mode.
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms);
        logic [31:0] r;
        r                                = ms;
        r[MSTATUS_MPIE]                  = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]                   = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // mstatus on MRET: restore MIE from MPIE and set MPIE.
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] ms);
        logic [31:0] r;
        r               = ms;
        r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/irq_prio.sv
// Combinational interrupt masking and priority encoding (MEI > MSI > MTI).
module irq_prio
    import rv_csr_pkg::*;
(
    input  logic [2:0]  irq_i,
    input  logic [31:0] mie_i,
    input  logic        glob_en_i,
    output logic        take_o,
    output logic [3:0]  cause_o
);

    logic [2:0] masked_s;
    logic       mie_unused_s;

    // Only the three standard enable bits matter here.
    assign mie_unused_s = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

    // Mask the pending lines and pick the highest-priority cause.
    always_comb begin
        masked_s = {irq_i[2] & mie_i[MIX_MEI],
                    irq_i[1] & mie_i[MIX_MTI],
                    irq_i[0] & mie_i[MIX_MSI]};
        take_o   = glob_en_i & (|masked_s);
        if (masked_s[2]) begin
            cause_o = CAUSE_MEI;
        end else if (masked_s[0]) begin
            cause_o = CAUSE_MSI;
        end else if (masked_s[1]) begin
            cause_o = CAUSE_MTI;
        end else begin
            cause_o = 4'd0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: sequences exception/interrupt entry and MRET,
// produces CSR write data and the fetch redirect.
module trap_ctrl
    import rv_csr_pkg::*;
#(
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        exc_valid_i,
    input  logic [3:0]  exc_cause_i,
    input  logic [31:0] exc_pc_i,
    input  logic [31:0] exc_tval_i,
    input  logic        mret_i,
    input  logic [2:0]  irq_i,
    input  logic [31:0] next_pc_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic        redirect_ready_i,
    output logic        busy_o,
    output logic        flush_o,
    output logic        we_exc_o,
    output logic        is_int_o,
    output logic [31:0] mcause_d_o,
    output logic [31:0] mepc_d_o,
    output logic [31:0] mtval_d_o,
    output logic [31:0] mstatus_d_o,
    output logic [31:0] mip_d_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);

    trap_state_e state_q, state_d;
    logic [3:0]  cause_q, cause_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tval_q, tval_d;
    logic        int_q, int_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        busy_q, flush_q, we_q, is_int_q, redirect_valid_q;

    logic        irq_take_s;
    logic [3:0]  irq_cause_s;
    logic [31:0] tvec_base_s;
    logic [31:0] trap_target_s;

    irq_prio u_irq_prio (
        .irq_i     (irq_i),
        .mie_i     (mie_i),
        .glob_en_i (mstatus_i[MSTATUS_MIE]),
        .take_o    (irq_take_s),
        .cause_o   (irq_cause_s)
    );

    // Trap vector: base for exceptions, base + 4*cause for vectored interrupts.
    always_comb begin
        tvec_base_s = {mtvec_i[31:2], 2'b00};
        if (VECTORED_EN && int_q && (mtvec_i[1:0] == MTVEC_MODE_VECTORED)) begin
            trap_target_s = tvec_base_s + {26'd0, cause_q, 2'b00};
        end else begin
            trap_target_s = tvec_base_s;
        end
    end

    // Next-state logic; request details are latched on the way into CAPTURE.
    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        pc_d          = pc_q;
        tval_d        = tval_q;
        int_d         = int_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (exc_valid_i) begin
                    state_d = ST_CAPTURE;
                    cause_d = exc_cause_i;
                    pc_d    = exc_pc_i;
                    tval_d  = exc_tval_i;
                    int_d   = 1'b0;
                end else if (mret_i) begin
                    state_d = ST_RET;
                end else if (irq_take_s) begin
                    state_d = ST_CAPTURE;
                    cause_d = irq_cause_s;
                    pc_d    = next_pc_i;
                    tval_d  = 32'd0;
                    int_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d       = ST_REDIRECT;
                redirect_pc_d = trap_target_s;
            end
            ST_RET: begin
                state_d       = ST_REDIRECT;
                redirect_pc_d = {mepc_i[31:2], 2'b00};
            end
            ST_REDIRECT: begin
                if (redirect_ready_i) begin
                    state_d       = ST_IDLE;
                    redirect_pc_d = 32'd0;
                end else begin
                    state_d = ST_REDIRECT;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                redirect_pc_d = 32'd0;
            end
        endcase
    end

    // State, latched trap details and registered control strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= ST_IDLE;
            cause_q          <= 4'd0;
            pc_q             <= 32'd0;
            tval_q           <= 32'd0;
            int_q            <= 1'b0;
            redirect_pc_q    <= 32'd0;
            busy_q           <= 1'b0;
            flush_q          <= 1'b0;
            we_q             <= 1'b0;
            is_int_q         <= 1'b0;
            redirect_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cause_q          <= cause_d;
            pc_q             <= pc_d;
            tval_q           <= tval_d;
            int_q            <= int_d;
            redirect_pc_q    <= redirect_pc_d;
            busy_q           <= (state_d != ST_IDLE);
            flush_q          <= (state_d == ST_CAPTURE) || (state_d == ST_RET);
            we_q             <= (state_d == ST_WRITE) || (state_d == ST_RET);
            is_int_q         <= (state_d == ST_WRITE) && int_d;
            redirect_valid_q <= (state_d == ST_REDIRECT);
        end
    end

    // CSR write data, driven only while the update strobe is active.
    always_comb begin
        mcause_d_o  = 32'd0;
        mepc_d_o    = 32'd0;
        mtval_d_o   = 32'd0;
        mstatus_d_o = 32'd0;
        mip_d_o     = 32'd0;
        case (state_q)
            ST_WRITE: begin
                mcause_d_o  = {int_q, 27'd0, cause_q};
                mepc_d_o    = {pc_q[31:2], 2'b00};
                mtval_d_o   = int_q ? 32'd0 : tval_q;
                mstatus_d_o = mstatus_on_trap(mstatus_i);
                mip_d_o     = mip_map(irq_i);
            end
            ST_RET: begin
                // mcause/mtval reflect the last trap, mepc passes through unchanged
                mcause_d_o  = {int_q, 27'd0, cause_q};
                mepc_d_o    = mepc_i;
                mtval_d_o   = int_q ? 32'd0 : tval_q;
                mstatus_d_o = mstatus_on_mret(mstatus_i);
                mip_d_o     = mip_map(irq_i);
            end
            default: begin
                mcause_d_o  = 32'd0;
                mepc_d_o    = 32'd0;
                mtval_d_o   = 32'd0;
                mstatus_d_o = 32'd0;
                mip_d_o     = 32'd0;
            end
        endcase
    end

    assign busy_o           = busy_q;
    assign flush_o          = flush_q;
    assign we_exc_o         = we_q;
    assign is_int_o         = is_int_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized
// requests checked against a behavioural model of the trap rules.
module tb_trap_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        exc_valid_i = 1'b0;
    logic [3:0]  exc_cause_i = 4'd0;
    logic [31:0] exc_pc_i = 32'd0;
    logic [31:0] exc_tval_i = 32'd0;
    logic        mret_i = 1'b0;
    logic [2:0]  irq_i = 3'd0;
    logic [31:0] next_pc_i = 32'd0;
    logic [31:0] mstatus_i = 32'd0;
    logic [31:0] mie_i = 32'd0;
    logic [31:0] mtvec_i = 32'd0;
    logic [31:0] mepc_i = 32'd0;
    logic        redirect_ready_i = 1'b0;
    logic        busy_o, flush_o, we_exc_o, is_int_o, redirect_valid_o;
    logic [31:0] mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o, mip_d_o, redirect_pc_o;

    int checks = 0;
    int errors = 0;

    // observation record of one sequence
    int          obs_flush, obs_we, obs_rv_step, obs_rv_cnt, obs_idle_step;
    bit          obs_done, obs_unstable;
    logic        obs_is_int;
    logic [31:0] obs_mcause, obs_mepc, obs_mtval, obs_mstatus, obs_mip, obs_pc;

    trap_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i),
        .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
        .mret_i(mret_i), .irq_i(irq_i), .next_pc_i(next_pc_i),
        .mstatus_i(mstatus_i), .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .redirect_ready_i(redirect_ready_i),
        .busy_o(busy_o), .flush_o(flush_o), .we_exc_o(we_exc_o), .is_int_o(is_int_o),
        .mcause_d_o(mcause_d_o), .mepc_d_o(mepc_d_o), .mtval_d_o(mtval_d_o),
        .mstatus_d_o(mstatus_d_o), .mip_d_o(mip_d_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_mip(input logic [2:0] irq);
        return (irq[2] ? 32'h0000_0800 : 32'h0) | (irq[1] ? 32'h0000_0080 : 32'h0) |
               (irq[0] ? 32'h0000_0008 : 32'h0);
    endfunction

    function automatic logic [31:0] exp_mst_trap(input logic [31:0] ms);
        return (ms & 32'hFFFF_E777) | (ms[3] ? 32'h0000_0080 : 32'h0) | 32'h0000_1800;
    endfunction

    function automatic logic [31:0] exp_mst_ret(input logic [31:0] ms);
        return (ms & 32'hFFFF_FF77) | (ms[7] ? 32'h0000_0008 : 32'h0) | 32'h0000_0080;
    endfunction

    // cause of the interrupt that would be taken, or -1 for none
    function automatic int irq_winner(input logic [2:0] irq, input logic [31:0] mie,
                                      input logic [31:0] ms);
        if (!ms[3]) return -1;
        if (irq[2] && mie[11]) return 11;
        if (irq[0] && mie[3]) return 3;
        if (irq[1] && mie[7]) return 7;
        return -1;
    endfunction

    function automatic logic [31:0] exp_int_target(input logic [31:0] mtvec, input int cause);
        logic [31:0] base;
        base = mtvec & 32'hFFFF_FFFC;
        if (mtvec[1:0] == 2'b01) return base + 32'(4 * cause);
        return base;
    endfunction

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Run one sequence to completion, recording what the DUT shows each cycle.
    task automatic observe(input int rdy_wait, input bit drop_irq);
        int rv_cnt;
        bit seen_busy;
        rv_cnt = 0; seen_busy = 1'b0;
        obs_flush = 0; obs_we = 0; obs_rv_step = 0; obs_idle_step = 0;
        obs_done = 1'b0; obs_unstable = 1'b0; obs_is_int = 1'b0;
        obs_mcause = 32'd0; obs_mepc = 32'd0; obs_mtval = 32'd0;
        obs_mstatus = 32'd0; obs_mip = 32'd0; obs_pc = 32'd0;
        redirect_ready_i = (rdy_wait == 0);
        for (int s = 1; s <= 40 && !obs_done; s++) begin
            step();
            if (busy_o) begin
                seen_busy = 1'b1;
                exc_valid_i = 1'b0;
                mret_i = 1'b0;
                if (drop_irq) irq_i = 3'd0;
            end
            if (flush_o) obs_flush++;
            if (we_exc_o) begin
                obs_we++;
                obs_mcause = mcause_d_o; obs_mepc = mepc_d_o; obs_mtval = mtval_d_o;
                obs_mstatus = mstatus_d_o; obs_mip = mip_d_o; obs_is_int = is_int_o;
            end
            if (redirect_valid_o) begin
                if (rv_cnt == 0) begin
                    obs_rv_step = s;
                    obs_pc = redirect_pc_o;
                end else if (redirect_pc_o !== obs_pc) begin
                    obs_unstable = 1'b1;
                end
                rv_cnt++;
                if (rv_cnt > rdy_wait) redirect_ready_i = 1'b1;
            end else if (seen_busy && !busy_o) begin
                obs_done = 1'b1;
                obs_idle_step = s;
            end
        end
        obs_rv_cnt = rv_cnt;
        redirect_ready_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_ni = 1'b0;
        step(); step();
        checks++;
        if ({busy_o, flush_o, we_exc_o, is_int_o, redirect_valid_o} !== 5'd0) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000",
                {busy_o, flush_o, we_exc_o, is_int_o, redirect_valid_o});
        end
        checks++;
        if ({mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o, mip_d_o, redirect_pc_o} !== 192'd0) begin
            errors++; $display("FAIL reset_data got mcause=%h mepc=%h mstatus=%h rpc=%h want 0",
                mcause_d_o, mepc_d_o, mstatus_d_o, redirect_pc_o);
        end
        rst_ni = 1'b1;
        step();
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle busy=%b want 0", busy_o); end
    endtask

    task automatic test_illegal();
        mstatus_i = 32'h0000_0008; mtvec_i = 32'h0000_0200; mie_i = 32'd0;
        exc_valid_i = 1'b1; exc_cause_i = 4'd2; exc_pc_i = 32'h100; exc_tval_i = 32'hDEAD;
        observe(0, 1'b0);
        checks++; if (!obs_done) begin errors++; $display("FAIL ill_done timeout"); end
        checks++; if (obs_flush !== 1) begin errors++; $display("FAIL ill_flush cnt=%0d want 1", obs_flush); end
        checks++; if (obs_we !== 1) begin errors++; $display("FAIL ill_we cnt=%0d want 1", obs_we); end
        checks++; if (obs_mepc !== 32'h100) begin errors++; $display("FAIL ill_mepc got %h want 100", obs_mepc); end
        checks++; if (obs_mcause !== 32'd2) begin errors++; $display("FAIL ill_mcause got %h want 2", obs_mcause); end
        checks++; if (obs_mtval !== 32'hDEAD) begin errors++; $display("FAIL ill_mtval got %h want dead", obs_mtval); end
        checks++; if ({obs_mstatus[7], obs_mstatus[3]} !== 2'b10) begin
            errors++; $display("FAIL ill_mstatus got %h want MPIE=1 MIE=0", obs_mstatus); end
        checks++; if (obs_pc !== 32'h200) begin errors++; $display("FAIL ill_pc got %h want 200", obs_pc); end
        checks++; if (obs_rv_step !== 3) begin errors++; $display("FAIL ill_latency got %0d want 3", obs_rv_step); end
    endtask

    task automatic test_vectored_irq();
        mstatus_i = 32'h0000_0008; mtvec_i = 32'h0000_0401; mie_i = 32'h0000_0080;
        next_pc_i = 32'h80; irq_i = 3'b010;
        observe(0, 1'b0);
        irq_i = 3'd0;
        checks++; if (!obs_done) begin errors++; $display("FAIL vec_done timeout"); end
        checks++; if (obs_mcause !== 32'h8000_0007) begin errors++; $display("FAIL vec_mcause got %h want 80000007", obs_mcause); end
        checks++; if (obs_mepc !== 32'h80) begin errors++; $display("FAIL vec_mepc got %h want 80", obs_mepc); end
        checks++; if (obs_mtval !== 32'd0) begin errors++; $display("FAIL vec_mtval got %h want 0", obs_mtval); end
        checks++; if (obs_is_int !== 1'b1) begin errors++; $display("FAIL vec_is_int got %b want 1", obs_is_int); end
        checks++; if (obs_mip !== 32'h80) begin errors++; $display("FAIL vec_mip got %h want 80", obs_mip); end
        checks++; if (obs_pc !== 32'h41C) begin errors++; $display("FAIL vec_pc got %h want 41c", obs_pc); end
    endtask

    task automatic test_mret();
        mstatus_i = 32'h0000_0080; mepc_i = 32'h84; mtvec_i = 32'h200;
        mret_i = 1'b1;
        observe(0, 1'b0);
        checks++; if (!obs_done) begin errors++; $display("FAIL mret_done timeout"); end
        checks++; if (obs_we !== 1 || obs_flush !== 1) begin
            errors++; $display("FAIL mret_strobes we=%0d flush=%0d want 1/1", obs_we, obs_flush); end
        checks++; if (obs_is_int !== 1'b0) begin errors++; $display("FAIL mret_is_int got %b want 0", obs_is_int); end
        checks++; if (obs_mstatus !== 32'h88) begin errors++; $display("FAIL mret_mstatus got %h want 88", obs_mstatus); end
        checks++; if (obs_mepc !== 32'h84) begin errors++; $display("FAIL mret_mepc got %h want 84", obs_mepc); end
        checks++; if (obs_pc !== 32'h84) begin errors++; $display("FAIL mret_pc got %h want 84", obs_pc); end
        checks++; if (obs_rv_step !== 2) begin errors++; $display("FAIL mret_latency got %0d want 2", obs_rv_step); end
    endtask

    task automatic test_simultaneous();
        bit took;
        mstatus_i = 32'h0000_0008; mie_i = 32'h0000_0800; mtvec_i = 32'h200; next_pc_i = 32'h340;
        irq_i = 3'b100; exc_valid_i = 1'b1; exc_cause_i = 4'd5; exc_pc_i = 32'h300; exc_tval_i = 32'h11;
        observe(0, 1'b0);
        checks++; if (obs_mcause !== 32'd5 || obs_is_int !== 1'b0) begin
            errors++; $display("FAIL sim_exc_first mcause=%h is_int=%b want 5/0", obs_mcause, obs_is_int); end
        // software-visible MIE is now off: MEI must stay pending
        mstatus_i = 32'h0000_1880;
        took = 1'b0;
        for (int i = 0; i < 4; i++) begin step(); if (busy_o) took = 1'b1; end
        checks++; if (took) begin errors++; $display("FAIL sim_masked busy=1 want 0"); end
        mstatus_i = 32'h0000_0008;
        observe(0, 1'b0);
        irq_i = 3'd0;
        checks++; if (!obs_done || obs_mcause !== 32'h8000_000B) begin
            errors++; $display("FAIL sim_mei got mcause=%h done=%b want 8000000b", obs_mcause, obs_done); end
        checks++; if (obs_pc !== 32'h200) begin errors++; $display("FAIL sim_mei_pc got %h want 200", obs_pc); end
    endtask

    task automatic test_backpressure();
        mstatus_i = 32'h0; mtvec_i = 32'h0000_0A00;
        exc_valid_i = 1'b1; exc_cause_i = 4'd7; exc_pc_i = 32'h124; exc_tval_i = 32'h0;
        observe(5, 1'b0);
        checks++; if (obs_rv_cnt !== 6) begin errors++; $display("FAIL bp_hold got %0d cycles want 6", obs_rv_cnt); end
        checks++; if (obs_unstable || obs_pc !== 32'hA00) begin
            errors++; $display("FAIL bp_pc got %h unstable=%b want a00", obs_pc, obs_unstable); end
        checks++; if (obs_idle_step !== obs_rv_step + 6) begin
            errors++; $display("FAIL bp_idle got step %0d want %0d", obs_idle_step, obs_rv_step + 6); end
    endtask

    task automatic test_reset_mid();
        bit found;
        mstatus_i = 32'h8; mtvec_i = 32'h600;
        exc_valid_i = 1'b1; exc_cause_i = 4'd6; exc_pc_i = 32'h500; exc_tval_i = 32'h77;
        found = 1'b0;
        for (int s = 0; s < 10 && !found; s++) begin
            step();
            if (busy_o) exc_valid_i = 1'b0;
            if (we_exc_o) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rstmid_reach no WRITE seen"); end
        exc_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({busy_o, flush_o, we_exc_o, is_int_o, redirect_valid_o} !== 5'd0 ||
            {mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o, mip_d_o, redirect_pc_o} !== 192'd0) begin
            errors++; $display("FAIL rstmid_zero busy=%b we=%b mepc=%h mstatus=%h want 0",
                busy_o, we_exc_o, mepc_d_o, mstatus_d_o);
        end
        step(); step();
        rst_ni = 1'b1;
        mtvec_i = 32'h603;
        exc_valid_i = 1'b1; exc_cause_i = 4'd1; exc_pc_i = 32'h706; exc_tval_i = 32'h9;
        observe(0, 1'b0);
        checks++; if (!obs_done || obs_mcause !== 32'd1 || obs_mepc !== 32'h704 || obs_pc !== 32'h600) begin
            errors++; $display("FAIL rstmid_after mcause=%h mepc=%h pc=%h want 1/704/600",
                obs_mcause, obs_mepc, obs_pc);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int kind, win, rdy, ecause;
            bit drop, took;
            logic [2:0] irq_v;
            logic [31:0] e_pc, e_mst, e_mcause, e_mepc, e_mtval;
            mstatus_i = $urandom; mie_i = $urandom; mtvec_i = $urandom; mepc_i = $urandom;
            next_pc_i = $urandom; exc_pc_i = $urandom; exc_tval_i = $urandom;
            ecause = $urandom_range(0, 15); exc_cause_i = 4'(ecause);
            exc_valid_i = ($urandom_range(0, 2) == 0);
            mret_i = ($urandom_range(0, 2) == 0);
            irq_v = 3'($urandom_range(0, 7)); irq_i = irq_v;
            drop = 1'($urandom_range(0, 1)); rdy = $urandom_range(0, 3);
            win = irq_winner(irq_v, mie_i, mstatus_i);
            kind = exc_valid_i ? 1 : (mret_i ? 2 : ((win >= 0) ? 3 : 0));
            if (kind == 0) begin
                took = 1'b0;
                for (int i = 0; i < 3; i++) begin step(); if (busy_o) took = 1'b1; end
                checks++; if (took) begin errors++; $display("FAIL rnd_none[%0d] busy seen", n); end
            end else begin
                observe(rdy, drop);
                if (kind == 1) begin
                    e_pc = mtvec_i & 32'hFFFF_FFFC; e_mst = exp_mst_trap(mstatus_i);
                    e_mcause = 32'(ecause); e_mepc = exc_pc_i & 32'hFFFF_FFFC; e_mtval = exc_tval_i;
                end else if (kind == 2) begin
                    e_pc = mepc_i & 32'hFFFF_FFFC; e_mst = exp_mst_ret(mstatus_i);
                    e_mcause = 32'd0; e_mepc = mepc_i; e_mtval = 32'd0;
                end else begin
                    e_pc = exp_int_target(mtvec_i, win); e_mst = exp_mst_trap(mstatus_i);
                    e_mcause = 32'h8000_0000 | 32'(win); e_mepc = next_pc_i & 32'hFFFF_FFFC; e_mtval = 32'd0;
                end
                checks++;
                if (!obs_done || obs_flush !== 1 || obs_we !== 1 || obs_unstable ||
                    obs_rv_step !== ((kind == 2) ? 2 : 3) || obs_rv_cnt !== rdy + 1) begin
                    errors++; $display("FAIL rnd_seq[%0d] kind=%0d done=%b flush=%0d we=%0d step=%0d rv=%0d want rv=%0d",
                        n, kind, obs_done, obs_flush, obs_we, obs_rv_step, obs_rv_cnt, rdy + 1);
                end
                checks++;
                if (obs_pc !== e_pc || obs_mstatus !== e_mst || obs_is_int !== (kind == 3) ||
                    obs_mepc !== e_mepc) begin
                    errors++; $display("FAIL rnd_data[%0d] kind=%0d pc=%h/%h mst=%h/%h int=%b mepc=%h/%h (got/want)",
                        n, kind, obs_pc, e_pc, obs_mstatus, e_mst, obs_is_int, obs_mepc, e_mepc);
                end
                if (kind != 2) begin
                    checks++;
                    if (obs_mcause !== e_mcause || obs_mtval !== e_mtval ||
                        obs_mip !== (drop ? 32'd0 : exp_mip(irq_v))) begin
                        errors++; $display("FAIL rnd_cause[%0d] mcause=%h/%h mtval=%h/%h mip=%h (got/want)",
                            n, obs_mcause, e_mcause, obs_mtval, e_mtval, obs_mip);
                    end
                end
            end
            exc_valid_i = 1'b0; mret_i = 1'b0; irq_i = 3'd0;
        end
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_vectored_irq();
        test_mret();
        test_simultaneous();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
